// File: rtl/fetch_pc_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fetch_pc_gen : fetch-side PC sequencer, one-deep instruction buffer.      |
// | Revision     : 1.0                                                        |
// +--------------------------------------------------------------------------+
module fetch_pc_gen #(
  parameter int unsigned       ADDR_W   = 15,
  parameter int unsigned       DATA_W   = 16,
  parameter int unsigned       INC      = 1,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_target,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_rsp_valid,
  input  logic [DATA_W-1:0] imem_rsp_data,
  output logic              inst_valid,
  output logic [DATA_W-1:0] inst_out,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              inst_ready,
  output logic [ADDR_W-1:0] pcaddinp,
  output logic              PCWrite
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] INC_A = ADDR_W'(INC);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;
  logic [ADDR_W-1:0] pcaddinp_q, pcaddinp_d;
  logic [DATA_W-1:0] inst_out_q, inst_out_d;
  logic              drop_q, drop_d;
  logic              inst_valid_q, inst_valid_d;
  logic              pcwrite_q, pcwrite_d;

  logic              redirect;
  logic [ADDR_W-1:0] tgt;
  logic              fire;
  logic              take;
  logic              pc_load;

  assign redirect       = jump | branch_taken;
  assign tgt            = jump ? jump_target : branch_target;
  assign imem_req_valid = (state_q == S_REQ) & ~stall;
  assign fire           = imem_req_valid & imem_req_ready;
  assign take           = inst_valid_q & inst_ready & ~stall;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drop_d       = drop_q;
    inst_valid_d = inst_valid_q;
    inst_out_d   = inst_out_q;
    inst_pc_d    = inst_pc_q;
    pc_load      = 1'b0;

    case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
        if (redirect) begin
          pc_d    = tgt;
          pc_load = 1'b1;
        end
      end
      S_REQ: begin
        if (redirect) begin
          pc_d    = tgt;
          pc_load = 1'b1;
        end
        if (fire) begin
          state_d = S_WAIT;
          drop_d  = redirect;
        end
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          // A redirect or a pending drop both discard this response.
          if (redirect) begin
            pc_d    = tgt;
            pc_load = 1'b1;
            drop_d  = 1'b0;
            state_d = S_REQ;
          end else if (drop_q) begin
            drop_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            inst_out_d   = imem_rsp_data;
            inst_pc_d    = pc_q;
            inst_valid_d = 1'b1;
            pc_d         = pc_q + INC_A;
            pc_load      = 1'b1;
            state_d      = S_HOLD;
          end
        end else if (redirect) begin
          pc_d    = tgt;
          pc_load = 1'b1;
          drop_d  = 1'b1;
        end
      end
      S_HOLD: begin
        if (redirect) begin
          inst_valid_d = 1'b0;
          pc_d         = tgt;
          pc_load      = 1'b1;
          state_d      = S_REQ;
        end else if (take) begin
          inst_valid_d = 1'b0;
          state_d      = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase

    pcwrite_d  = pc_load;
    pcaddinp_d = pc_load ? pc_d : pcaddinp_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      drop_q       <= 1'b0;
      inst_valid_q <= 1'b0;
      inst_out_q   <= '0;
      inst_pc_q    <= '0;
      pcaddinp_q   <= RESET_PC;
      pcwrite_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drop_q       <= drop_d;
      inst_valid_q <= inst_valid_d;
      inst_out_q   <= inst_out_d;
      inst_pc_q    <= inst_pc_d;
      pcaddinp_q   <= pcaddinp_d;
      pcwrite_q    <= pcwrite_d;
    end
  end

  assign imem_addr  = pc_q;
  assign inst_valid = inst_valid_q;
  assign inst_out   = inst_out_q;
  assign inst_pc    = inst_pc_q;
  assign pcaddinp   = pcaddinp_q;
  assign PCWrite    = pcwrite_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_pc_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fetch_pc_gen : scoreboard bench for fetch_pc_gen (default + wrap PC).  |
// | Revision        : 1.0                                                     |
// +--------------------------------------------------------------------------+
module tb_fetch_pc_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [14:0] branch_target = '0;
  logic        jump = 1'b0;
  logic [14:0] jump_target = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [14:0] imem_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [15:0] imem_rsp_data = '0;
  logic        inst_valid;
  logic [15:0] inst_out;
  logic [14:0] inst_pc;
  logic        inst_ready = 1'b1;
  logic [14:0] pcaddinp;
  logic        PCWrite;

  logic        w_rst = 1'b1;
  logic        w_one = 1'b1;
  logic        w_zero = 1'b0;
  logic [14:0] w_zaddr = '0;
  logic        w_req_valid;
  logic [14:0] w_addr;
  logic        w_rsp_valid = 1'b0;
  logic [15:0] w_rsp_data = '0;
  logic        w_inst_valid;
  logic [15:0] w_inst_out;
  logic [14:0] w_inst_pc;
  logic [14:0] w_pcaddinp;
  logic        w_pcwrite;

  int n_cmp = 0;
  int n_err = 0;

  int          lat = 1;
  int          rsp_cnt = 0;
  logic [14:0] rsp_addr = '0;
  logic        ovr_en = 1'b0;
  logic [15:0] ovr_data = '0;
  logic        w_pend = 1'b0;
  logic [14:0] w_paddr = '0;

  logic [14:0] q_fire[$];
  logic [14:0] q_ipc[$];
  logic [15:0] q_idata[$];
  logic [14:0] q_pcw[$];

  logic fire_m, take_m, w_fire, w_take;
  assign fire_m = imem_req_valid & imem_req_ready;
  assign take_m = inst_valid & inst_ready & ~stall;
  assign w_fire = w_req_valid;
  assign w_take = w_inst_valid;

  always #5 clk = ~clk;

  function automatic logic [15:0] mk_data(input logic [14:0] a);
    return {1'b0, a} ^ 16'hC3C3;
  endfunction

  fetch_pc_gen u_dut (
    .clk(clk), .rst(rst), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_addr(imem_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .inst_valid(inst_valid),
    .inst_out(inst_out), .inst_pc(inst_pc), .inst_ready(inst_ready),
    .pcaddinp(pcaddinp), .PCWrite(PCWrite)
  );

  fetch_pc_gen #(.RESET_PC(15'h7FFF)) u_wrap (
    .clk(clk), .rst(w_rst), .stall(w_zero),
    .branch_taken(w_zero), .branch_target(w_zaddr),
    .jump(w_zero), .jump_target(w_zaddr),
    .imem_req_valid(w_req_valid), .imem_req_ready(w_one),
    .imem_addr(w_addr), .imem_rsp_valid(w_rsp_valid),
    .imem_rsp_data(w_rsp_data), .inst_valid(w_inst_valid),
    .inst_out(w_inst_out), .inst_pc(w_inst_pc), .inst_ready(w_one),
    .pcaddinp(w_pcaddinp), .PCWrite(w_pcwrite)
  );

  // Instruction memory: one response per fire, 'lat' cycles after the fire.
  always @(negedge clk) begin
    imem_rsp_valid = 1'b0;
    if (rsp_cnt > 0) begin
      rsp_cnt = rsp_cnt - 1;
      if (rsp_cnt == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = ovr_en ? ovr_data : mk_data(rsp_addr);
      end
    end
    if (fire_m === 1'b1) begin
      rsp_cnt  = lat;
      rsp_addr = imem_addr;
    end
  end

  always @(negedge clk) begin
    w_rsp_valid = w_pend;
    w_rsp_data  = mk_data(w_paddr);
    w_pend      = (w_fire === 1'b1);
    w_paddr     = w_addr;
  end

  task automatic apply_reset(input logic rdy);
    @(posedge clk); #1;
    rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; jump = 1'b0;
    inst_ready = rdy; imem_req_ready = 1'b1; ovr_en = 1'b0; lat = 1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (imem_req_valid !== 1'b0) begin n_err++; $display("FAIL reset_req_valid: got %b want 0", imem_req_valid); end
    n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL reset_inst_valid: got %b want 0", inst_valid); end
    n_cmp++; if (inst_out !== 16'h0) begin n_err++; $display("FAIL reset_inst_out: got %h want 0000", inst_out); end
    n_cmp++; if (inst_pc !== 15'h0) begin n_err++; $display("FAIL reset_inst_pc: got %h want 0000", inst_pc); end
    n_cmp++; if (pcaddinp !== 15'h0) begin n_err++; $display("FAIL reset_pcaddinp: got %h want 0000", pcaddinp); end
    n_cmp++; if (PCWrite !== 1'b0) begin n_err++; $display("FAIL reset_pcwrite: got %b want 0", PCWrite); end
    n_cmp++; if (imem_addr !== 15'h0) begin n_err++; $display("FAIL reset_addr: got %h want 0000", imem_addr); end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (imem_req_valid !== 1'b0) begin n_err++; $display("FAIL idle_req_valid: got %b want 0", imem_req_valid); end
    @(negedge clk);
    n_cmp++; if (imem_req_valid !== 1'b1) begin n_err++; $display("FAIL req_after_idle: got %b want 1", imem_req_valid); end
  endtask

  task automatic test_free_run();
    int cyc;
    logic [14:0] e;
    apply_reset(1'b1);
    q_fire.delete(); q_ipc.delete(); q_pcw.delete();
    for (int i = 0; i < 4; i++) begin
      q_fire.push_back(15'(i));
      q_ipc.push_back(15'(i));
      q_pcw.push_back(15'(i + 1));
    end
    cyc = 0;
    while ((q_fire.size() + q_ipc.size() + q_pcw.size()) != 0 && cyc < 60) begin
      @(negedge clk); cyc++;
      if (fire_m && q_fire.size() != 0) begin
        e = q_fire.pop_front();
        n_cmp++; if (imem_addr !== e) begin n_err++; $display("FAIL run_fire_addr: got %h want %h", imem_addr, e); end
      end
      if (take_m && q_ipc.size() != 0) begin
        e = q_ipc.pop_front();
        n_cmp++; if (inst_pc !== e) begin n_err++; $display("FAIL run_inst_pc: got %h want %h", inst_pc, e); end
        n_cmp++; if (inst_out !== mk_data(e)) begin n_err++; $display("FAIL run_inst_out: got %h want %h", inst_out, mk_data(e)); end
      end
      if (PCWrite && q_pcw.size() != 0) begin
        e = q_pcw.pop_front();
        n_cmp++; if (pcaddinp !== e) begin n_err++; $display("FAIL run_pcaddinp: got %h want %h", pcaddinp, e); end
      end
    end
    if ((q_fire.size() + q_ipc.size() + q_pcw.size()) != 0) begin
      n_cmp++; n_err++; $display("FAIL run_timeout: got %0d pending want 0", q_fire.size() + q_ipc.size() + q_pcw.size());
    end
  endtask

  task automatic test_stall_hold();
    int cyc;
    logic [14:0] e;
    logic [15:0] d;
    apply_reset(1'b0);
    ovr_en = 1'b1; ovr_data = 16'hA5A5;
    q_ipc.delete(); q_idata.delete(); q_fire.delete();
    q_ipc.push_back(15'h0); q_idata.push_back(16'hA5A5);
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!inst_valid && cyc < 20);
    e = q_ipc.pop_front(); d = q_idata.pop_front();
    n_cmp++; if (inst_valid !== 1'b1) begin n_err++; $display("FAIL stall_fill: got %b want 1", inst_valid); end
    n_cmp++; if (inst_pc !== e) begin n_err++; $display("FAIL stall_inst_pc: got %h want %h", inst_pc, e); end
    @(posedge clk); #1 stall = 1'b1; inst_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++; if (inst_valid !== 1'b1) begin n_err++; $display("FAIL stall_valid: got %b want 1", inst_valid); end
      n_cmp++; if (inst_out !== d) begin n_err++; $display("FAIL stall_out: got %h want %h", inst_out, d); end
      n_cmp++; if (inst_pc !== e) begin n_err++; $display("FAIL stall_pc: got %h want %h", inst_pc, e); end
      n_cmp++; if (imem_req_valid !== 1'b0) begin n_err++; $display("FAIL stall_no_req: got %b want 0", imem_req_valid); end
    end
    @(posedge clk); #1 stall = 1'b0; ovr_en = 1'b0;
    q_fire.push_back(15'h1);
    @(negedge clk);
    n_cmp++; if (take_m !== 1'b1) begin n_err++; $display("FAIL stall_release_take: got %b want 1", take_m); end
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!fire_m && cyc < 10);
    e = q_fire.pop_front();
    n_cmp++; if (fire_m !== 1'b1 || imem_addr !== e) begin n_err++; $display("FAIL stall_next_fire: got %b/%h want 1/%h", fire_m, imem_addr, e); end
  endtask

  task automatic test_redirect_wait();
    int cyc;
    logic found, saw_v;
    logic [14:0] e;
    apply_reset(1'b1);
    lat = 3;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (fire_m && imem_addr == 15'h4) found = 1'b1;
    end
    n_cmp++; if (found !== 1'b1) begin n_err++; $display("FAIL redir_find_pc4: got %b want 1", found); end
    @(posedge clk); #1 branch_taken = 1'b1; branch_target = 15'h0100;
    @(posedge clk); #1 branch_taken = 1'b0;
    q_fire.delete(); q_fire.push_back(15'h0100);
    @(negedge clk);
    n_cmp++; if (PCWrite !== 1'b1 || pcaddinp !== 15'h0100) begin n_err++; $display("FAIL redir_pcwrite: got %b/%h want 1/0100", PCWrite, pcaddinp); end
    n_cmp++; if (imem_addr !== 15'h0100) begin n_err++; $display("FAIL redir_addr: got %h want 0100", imem_addr); end
    saw_v = inst_valid; cyc = 0;
    while (!fire_m && cyc < 20) begin @(negedge clk); cyc++; saw_v = saw_v | inst_valid; end
    e = q_fire.pop_front();
    n_cmp++; if (saw_v !== 1'b0) begin n_err++; $display("FAIL redir_discard: got inst_valid %b want 0", saw_v); end
    n_cmp++; if (fire_m !== 1'b1 || imem_addr !== e) begin n_err++; $display("FAIL redir_fire: got %b/%h want 1/%h", fire_m, imem_addr, e); end
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!inst_valid && cyc < 20);
    n_cmp++; if (inst_valid !== 1'b1 || inst_pc !== 15'h0100) begin n_err++; $display("FAIL redir_inst_pc: got %b/%h want 1/0100", inst_valid, inst_pc); end
    n_cmp++; if (inst_out !== mk_data(15'h0100)) begin n_err++; $display("FAIL redir_inst_out: got %h want %h", inst_out, mk_data(15'h0100)); end
    lat = 1;
  endtask

  task automatic test_jump_branch_hold();
    int cyc;
    logic [14:0] e;
    apply_reset(1'b0);
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!inst_valid && cyc < 20);
    n_cmp++; if (inst_valid !== 1'b1) begin n_err++; $display("FAIL jb_fill: got %b want 1", inst_valid); end
    @(posedge clk); #1
    jump = 1'b1; jump_target = 15'h0200; branch_taken = 1'b1; branch_target = 15'h0300;
    @(posedge clk); #1 jump = 1'b0; branch_taken = 1'b0;
    q_fire.delete(); q_fire.push_back(15'h0200);
    @(negedge clk);
    n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL jb_flush: got %b want 0", inst_valid); end
    n_cmp++; if (PCWrite !== 1'b1 || pcaddinp !== 15'h0200) begin n_err++; $display("FAIL jb_pcwrite: got %b/%h want 1/0200", PCWrite, pcaddinp); end
    cyc = 0;
    while (!fire_m && cyc < 10) begin @(negedge clk); cyc++; end
    e = q_fire.pop_front();
    n_cmp++; if (fire_m !== 1'b1 || imem_addr !== e) begin n_err++; $display("FAIL jb_fire: got %b/%h want 1/%h", fire_m, imem_addr, e); end
  endtask

  task automatic test_mid_reset();
    int cyc;
    logic found, saw_v;
    logic [14:0] e;
    apply_reset(1'b1);
    lat = 2;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (fire_m && imem_addr == 15'h2) found = 1'b1;
    end
    n_cmp++; if (found !== 1'b1) begin n_err++; $display("FAIL mrst_find_pc2: got %b want 1", found); end
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    q_fire.delete(); q_fire.push_back(15'h0);
    @(negedge clk);
    n_cmp++; if (PCWrite !== 1'b0 || pcaddinp !== 15'h0) begin n_err++; $display("FAIL mrst_pc_state: got %b/%h want 0/0000", PCWrite, pcaddinp); end
    n_cmp++; if (imem_req_valid !== 1'b0) begin n_err++; $display("FAIL mrst_idle: got %b want 0", imem_req_valid); end
    saw_v = inst_valid; cyc = 0;
    while (!fire_m && cyc < 20) begin @(negedge clk); cyc++; saw_v = saw_v | inst_valid; end
    e = q_fire.pop_front();
    n_cmp++; if (saw_v !== 1'b0) begin n_err++; $display("FAIL mrst_stray_rsp: got inst_valid %b want 0", saw_v); end
    n_cmp++; if (fire_m !== 1'b1 || imem_addr !== e) begin n_err++; $display("FAIL mrst_fire: got %b/%h want 1/%h", fire_m, imem_addr, e); end
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!inst_valid && cyc < 20);
    n_cmp++; if (inst_pc !== 15'h0 || inst_out !== mk_data(15'h0)) begin n_err++; $display("FAIL mrst_inst: got %h/%h want 0000/%h", inst_pc, inst_out, mk_data(15'h0)); end
    lat = 1;
  endtask

  task automatic test_wrap();
    logic [14:0] wq[$];
    logic [14:0] e;
    logic took, pw;
    int cyc;
    @(negedge clk);
    n_cmp++; if (w_pcaddinp !== 15'h7FFF || w_addr !== 15'h7FFF) begin n_err++; $display("FAIL wrap_reset: got %h/%h want 7fff/7fff", w_pcaddinp, w_addr); end
    @(posedge clk); #1 w_rst = 1'b0;
    wq.push_back(15'h7FFF); wq.push_back(15'h0000);
    took = 1'b0; pw = 1'b0; cyc = 0;
    while (wq.size() != 0 && cyc < 30) begin
      @(negedge clk); cyc++;
      if (w_fire) begin
        e = wq.pop_front();
        n_cmp++; if (w_addr !== e) begin n_err++; $display("FAIL wrap_fire: got %h want %h", w_addr, e); end
      end
      if (w_take && !took) begin
        took = 1'b1;
        n_cmp++; if (w_inst_pc !== 15'h7FFF || w_inst_out !== mk_data(15'h7FFF)) begin n_err++; $display("FAIL wrap_inst: got %h/%h want 7fff/%h", w_inst_pc, w_inst_out, mk_data(15'h7FFF)); end
      end
      if (w_pcwrite && !pw) begin
        pw = 1'b1;
        n_cmp++; if (w_pcaddinp !== 15'h0000) begin n_err++; $display("FAIL wrap_pcaddinp: got %h want 0000", w_pcaddinp); end
      end
    end
    n_cmp++; if (wq.size() != 0 || !took || !pw) begin n_err++; $display("FAIL wrap_timeout: got pending %0d took %b pw %b want 0/1/1", wq.size(), took, pw); end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_stall_hold();
    test_redirect_wait();
    test_jump_branch_hold();
    test_mid_reset();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
